// File: rtl/oven_thermal_ctrl_if.sv
// Front-end/display bundle for the oven bake controller.
// The keypad side drives the master modport; the controller uses slave.
interface oven_thermal_ctrl_if #(
  parameter int TEMP_W = 10,
  parameter int TIME_W = 10,
  parameter int DIGITS = 3
);
  logic                  start;
  logic                  abort;
  logic [TEMP_W-1:0]     set_temp;
  logic [TIME_W-1:0]     bake_time;
  logic                  door_open;
  logic [TEMP_W-1:0]     cur_temp;
  logic [4*DIGITS-1:0]   temp_bcd;
  logic [TIME_W-1:0]     time_left;
  logic [2:0]            phase;
  logic                  at_temp;
  logic                  done;

  modport master (
    output start, abort, set_temp, bake_time, door_open,
    input  cur_temp, temp_bcd, time_left, phase, at_temp, done
  );

  modport slave (
    input  start, abort, set_temp, bake_time, door_open,
    output cur_temp, temp_bcd, time_left, phase, at_temp, done
  );
endinterface

// File: rtl/oven_thermal_ctrl.sv
// Oven bake phase machine (preheat / hold / cool) with a tick-driven thermal model.
// Define OVEN_DOOR_SENSE_EN to pause the bake while the door is open.
module oven_thermal_ctrl #(
  parameter int TEMP_W    = 10,
  parameter int TIME_W    = 10,
  parameter int AMBIENT   = 65,
  parameter int MAX_TEMP  = 550,
  parameter int HEAT_STEP = 2,
  parameter int COOL_STEP = 2,
  parameter int TICK_DIV  = 50000000,
  parameter int DIGITS    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  oven_thermal_ctrl_if.slave bus
);

  localparam int TW1 = TEMP_W + 1;
  localparam int PW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0]     PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [TEMP_W-1:0] AMB_T     = TEMP_W'(AMBIENT);
  localparam logic [TEMP_W-1:0] MAX_T     = TEMP_W'(MAX_TEMP);
  localparam logic [TW1-1:0]    AMB_X     = TW1'(AMBIENT);
  localparam logic [TW1-1:0]    HEAT_X    = TW1'(HEAT_STEP);
  localparam logic [TW1-1:0]    COOL_X    = TW1'(COOL_STEP);
  localparam logic [TW1-1:0]    TEN_X     = TW1'(10);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREHEAT = 3'd1,
    HOLD    = 3'd2,
    COOL    = 3'd3,
    DONE    = 3'd4
  } phase_e;

  phase_e                phase_q, phase_d;
  logic [TEMP_W-1:0]     cur_temp_q, cur_temp_d;
  logic [TEMP_W-1:0]     target_q, target_d;
  logic [TIME_W-1:0]     time_left_q, time_left_d;
  logic [4*DIGITS-1:0]   temp_bcd_q, temp_bcd_d;
  logic                  done_q, done_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic                  tick;
  logic                  door_open;
  logic [TW1-1:0]        heat_x, cool_x;
  logic [TEMP_W-1:0]     heated, cooled, clamped;

`ifdef OVEN_DOOR_SENSE_EN
  assign door_open = bus.door_open;
`else
  assign door_open = 1'b0;
`endif

  function automatic logic [4*DIGITS-1:0] to_bcd(input logic [TEMP_W-1:0] v);
    logic [4*DIGITS-1:0] res;
    logic [TW1-1:0]      rem;
    logic [TW1-1:0]      digit;
    res = '0;
    rem = {1'b0, v};
    for (int k = 0; k < DIGITS; k++) begin
      digit          = rem % TEN_X;
      res[4*k +: 4]  = digit[3:0];
      rem            = rem / TEN_X;
    end
    return res;
  endfunction

  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Temperature math is one bit wider so ramps near the top of range never wrap.
  always_comb begin
    heat_x  = {1'b0, cur_temp_q} + HEAT_X;
    heated  = (heat_x >= {1'b0, target_q}) ? target_q : heat_x[TEMP_W-1:0];
    cool_x  = ({1'b0, cur_temp_q} >= AMB_X + COOL_X) ? ({1'b0, cur_temp_q} - COOL_X) : AMB_X;
    cooled  = cool_x[TEMP_W-1:0];
    clamped = (bus.set_temp < AMB_T) ? AMB_T :
              (bus.set_temp > MAX_T) ? MAX_T : bus.set_temp;
  end

  always_comb begin
    phase_d     = phase_q;
    cur_temp_d  = cur_temp_q;
    target_d    = target_q;
    time_left_d = time_left_q;
    temp_bcd_d  = to_bcd(cur_temp_q);
    done_d      = 1'b0;

    unique case (phase_q)
      IDLE, DONE: begin
        if (bus.start && !bus.abort) begin
          target_d    = clamped;
          time_left_d = bus.bake_time;
          phase_d     = PREHEAT;
        end
      end
      PREHEAT: begin
        if (bus.abort) begin
          phase_d     = COOL;
          time_left_d = '0;
        end else if (tick && !door_open) begin
          if (cur_temp_q == target_q) phase_d = HOLD;
          else                        cur_temp_d = heated;
        end
      end
      HOLD: begin
        // A door-open sag leaves cur_temp below target; closing re-enters the ramp.
        if (bus.abort) begin
          phase_d     = COOL;
          time_left_d = '0;
        end else if (door_open) begin
          if (tick) cur_temp_d = cooled;
        end else if (cur_temp_q != target_q) begin
          phase_d = PREHEAT;
        end else if (tick) begin
          if (time_left_q == '0) phase_d = COOL;
          else                   time_left_d = time_left_q - TIME_W'(1);
        end
      end
      COOL: begin
        if (tick) begin
          if (cur_temp_q == AMB_T) phase_d = DONE;
          else                     cur_temp_d = cooled;
        end
      end
      default: phase_d = IDLE;
    endcase

    done_d = (phase_d == DONE) && (phase_q != DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= IDLE;
      cur_temp_q  <= AMB_T;
      target_q    <= AMB_T;
      time_left_q <= '0;
      temp_bcd_q  <= to_bcd(AMB_T);
      done_q      <= 1'b0;
      presc_q     <= '0;
    end else begin
      phase_q     <= phase_d;
      cur_temp_q  <= cur_temp_d;
      target_q    <= target_d;
      time_left_q <= time_left_d;
      temp_bcd_q  <= temp_bcd_d;
      done_q      <= done_d;
      presc_q     <= presc_d;
    end
  end

  assign bus.cur_temp  = cur_temp_q;
  assign bus.temp_bcd  = temp_bcd_q;
  assign bus.time_left = time_left_q;
  assign bus.phase     = phase_q;
  assign bus.done      = done_q;
  assign bus.at_temp   = (phase_q == PREHEAT || phase_q == HOLD || phase_q == COOL) &&
                         (cur_temp_q == target_q);

endmodule

// File: tb/tb_oven_thermal_ctrl.sv
// Scoreboard bench for oven_thermal_ctrl: a behavioural bake model predicts every
// cycle, a separate monitor compares the DUT against the queued predictions.
module tb_oven_thermal_ctrl;

  localparam int TEMP_W    = 10;
  localparam int TIME_W    = 10;
  localparam int AMBIENT   = 65;
  localparam int MAX_TEMP  = 550;
  localparam int HEAT_STEP = 2;
  localparam int COOL_STEP = 2;
  localparam int TICK_DIV  = 4;
  localparam int DIGITS    = 3;
  localparam int RANDOM_CYCLES = 20000;

  typedef struct {
    int phase;
    int temp;
    int left;
    int bcd;
    bit atTemp;
    bit done;
  } expect_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oven_thermal_ctrl_if #(.TEMP_W(TEMP_W), .TIME_W(TIME_W), .DIGITS(DIGITS)) bus();

  oven_thermal_ctrl #(
    .TEMP_W(TEMP_W), .TIME_W(TIME_W), .AMBIENT(AMBIENT), .MAX_TEMP(MAX_TEMP),
    .HEAT_STEP(HEAT_STEP), .COOL_STEP(COOL_STEP), .TICK_DIV(TICK_DIV), .DIGITS(DIGITS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  expect_t expQ[$];
  int checks = 0;
  int errors = 0;
  int cycle = 0;

  // Behavioural model of the bake: phase numbers are the externally visible codes.
  int mPhase, mTemp, mLeft, mTarget, mPresc;

  function automatic int decimalBcd(input int t);
    int v, r;
    v = t;
    r = 0;
    for (int k = 0; k < DIGITS; k++) begin
      r = r + ((v % 10) << (4 * k));
      v = v / 10;
    end
    return r;
  endfunction

  function automatic expect_t resetRecord();
    expect_t e;
    e.phase = 0; e.temp = AMBIENT; e.left = 0;
    e.bcd = decimalBcd(AMBIENT); e.atTemp = 1'b0; e.done = 1'b0;
    return e;
  endfunction

  task automatic modelReset();
    mPhase = 0; mTemp = AMBIENT; mLeft = 0; mTarget = AMBIENT; mPresc = 0;
  endtask

  task automatic modelStep(input bit st, input bit ab, input int setT, input int bt,
                           output expect_t e);
    int  oldTemp, oldPhase;
    bit  tick;
    oldTemp  = mTemp;
    oldPhase = mPhase;
    tick     = (mPresc == TICK_DIV - 1);
    mPresc   = tick ? 0 : mPresc + 1;
    if (ab && (mPhase == 1 || mPhase == 2)) begin
      mPhase = 3;
      mLeft  = 0;
    end else if (st && !ab && (mPhase == 0 || mPhase == 4)) begin
      mTarget = (setT < AMBIENT) ? AMBIENT : ((setT > MAX_TEMP) ? MAX_TEMP : setT);
      mLeft   = bt;
      mPhase  = 1;
    end else if (tick) begin
      case (mPhase)
        1: if (mTemp == mTarget) mPhase = 2;
           else mTemp = (mTemp + HEAT_STEP > mTarget) ? mTarget : mTemp + HEAT_STEP;
        2: if (mLeft == 0) mPhase = 3;
           else mLeft = mLeft - 1;
        3: if (mTemp == AMBIENT) mPhase = 4;
           else mTemp = (mTemp - COOL_STEP < AMBIENT) ? AMBIENT : mTemp - COOL_STEP;
        default: ;
      endcase
    end
    e.phase  = mPhase;
    e.temp   = mTemp;
    e.left   = mLeft;
    e.bcd    = decimalBcd(oldTemp);
    e.atTemp = (mPhase >= 1 && mPhase <= 3) && (mTemp == mTarget);
    e.done   = (mPhase == 4) && (oldPhase != 4);
  endtask

  task automatic applyStimulus(input bit st, input bit ab, input bit door,
                               input int setT, input int bt, input bit rstN);
    expect_t e;
    @(negedge clk);
    bus.start     = st;
    bus.abort     = ab;
    bus.door_open = door;
    bus.set_temp  = TEMP_W'(setT);
    bus.bake_time = TIME_W'(bt);
    rst_n         = rstN;
    if (!rstN) begin
      modelReset();
      e = resetRecord();
    end else begin
      modelStep(st, ab, setT, bt, e);
    end
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string tag, input expect_t e);
    checks++;
    if (bus.phase !== 3'(e.phase) || bus.cur_temp !== TEMP_W'(e.temp) ||
        bus.time_left !== TIME_W'(e.left) || bus.temp_bcd !== (4*DIGITS)'(e.bcd) ||
        bus.at_temp !== e.atTemp || bus.done !== e.done) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got phase=%0d temp=%0d left=%0d bcd=%h at=%b done=%b required phase=%0d temp=%0d left=%0d bcd=%h at=%b done=%b",
               tag, cycle, bus.phase, bus.cur_temp, bus.time_left, bus.temp_bcd, bus.at_temp, bus.done,
               e.phase, e.temp, e.left, e.bcd[4*DIGITS-1:0], e.atTemp, e.done);
    end
  endtask

  task automatic idleUntilPhase(input int ph, input int maxCycles, input string tag);
    int n;
    n = 0;
    while (mPhase != ph && n < maxCycles) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
      n++;
    end
    if (mPhase != ph) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout got phase=%0d required phase=%0d", tag, mPhase, ph);
    end
  endtask

  // Monitor: one prediction per clock edge once stimulus has started.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("scoreboard", e);
      end
    end
  end

  initial begin
    bit st, ab, door;
    int setT, bt, n;
    bus.start = 1'b0; bus.abort = 1'b0; bus.door_open = 1'b0;
    bus.set_temp = '0; bus.bake_time = '0;
    modelReset();

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);

    $display("[TB] basic bake 71/2");
    applyStimulus(1'b1, 1'b0, 1'b0, 71, 2, 1'b1);
    idleUntilPhase(4, 200, "bake71");

    $display("[TB] odd gap 70, clamps 20 and 900");
    applyStimulus(1'b1, 1'b0, 1'b0, 70, 1, 1'b1);
    idleUntilPhase(4, 200, "bake70");
    applyStimulus(1'b1, 1'b0, 1'b0, 20, 0, 1'b1);
    idleUntilPhase(4, 200, "bake20");
    applyStimulus(1'b1, 1'b0, 1'b0, 900, 3, 1'b1);
    idleUntilPhase(4, 5000, "bake900");

    $display("[TB] abort in hold, start in cool");
    applyStimulus(1'b1, 1'b0, 1'b0, 75, 10, 1'b1);
    n = 0;
    while (!(mPhase == 2 && mLeft == 5) && n < 300) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
      n++;
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 71, 2, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 71, 2, 1'b1);
    idleUntilPhase(4, 300, "abort");

    $display("[TB] async reset mid-preheat");
    applyStimulus(1'b1, 1'b0, 1'b0, 100, 1, 1'b1);
    n = 0;
    while (!(mPhase == 1 && mTemp == 81) && n < 300) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
      n++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    #1;
    checkOutput("async_reset", resetRecord());
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < RANDOM_CYCLES; i++) begin
      st   = ($urandom_range(7) == 0);
      ab   = ($urandom_range(299) == 0);
      door = 1'($urandom_range(1));
      setT = ($urandom_range(9) == 0) ? int'($urandom_range(1023)) : int'($urandom_range(120, 40));
      bt   = int'($urandom_range(6));
      applyStimulus(st, ab, door, setT, bt, 1'b1);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
